// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: control FSM for the memory-to-memory vector datapath.
// Walks len elements: reads A[i] and B[i] from a single-port memory, applies
// op (add / sub / and / or) and writes C[i]. Three cycles per element.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start, op, src_a, src_b, dst, len
//                           command; sampled only in IDLE or DONE
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata
//                           memory port (1-cycle read latency)
//   busy, Done, cycle_count status and busy-cycle count of the last command
module vec_mem_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              Done,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  src_a_q;
    logic [ADDR_W-1:0]  src_b_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [DATA_W-1:0]  a_reg;

    logic               accept_c;
    logic               last_c;

    assign accept_c = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign last_c   = (idx == (len_q - LEN_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  state_nxt = S_RD_B;
            S_RD_B:  state_nxt = S_WR;
            S_WR:    state_nxt = last_c ? S_DONE : S_RD_A;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state/index; strobes are suppressed while reset is
    // asserted so an abort never lands a write on the reset edge.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_RD_A: begin
                mem_addr = src_a_q + ADDR_W'(idx);
                mem_rd   = ~reset;
                busy     = 1'b1;
            end
            S_RD_B: begin
                mem_addr = src_b_q + ADDR_W'(idx);
                mem_rd   = ~reset;
                busy     = 1'b1;
            end
            S_WR: begin
                mem_addr = dst_q + ADDR_W'(idx);
                mem_wr   = ~reset;
                busy     = 1'b1;
                case (op_q)
                    2'b00:   mem_wdata = a_reg + mem_rdata;
                    2'b01:   mem_wdata = a_reg - mem_rdata;
                    2'b10:   mem_wdata = a_reg & mem_rdata;
                    default: mem_wdata = a_reg | mem_rdata;
                endcase
            end
            S_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    // Command capture, element index, A operand and busy-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx         <= '0;
            a_reg       <= '0;
            cycle_count <= '0;
        end else begin
            if (accept_c) begin
                op_q    <= op;
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
                len_q   <= len;
                idx     <= '0;
            end else if ((state == S_WR) && !last_c) begin
                idx <= idx + LEN_W'(1);
            end

            // A[i] read in RD_A arrives during RD_B
            if (state == S_RD_B) begin
                a_reg <= mem_rdata;
            end

            if (accept_c) begin
                cycle_count <= '0;
            end else if (busy) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a behavioural single-port memory.
module tb_vec_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] src_a, src_b, dst;
    logic [7:0]  len;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy, Done;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    vec_mem_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .len        (len),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .Done       (Done),
        .cycle_count(cycle_count)
    );

    // Memory model with a bench-side preload port
    logic [15:0] mem [0:65535];
    logic        poke_we = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_data = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] rd_log [$];

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
            rd_log.push_back(mem_addr);
        end
        if (poke_we) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_we   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1;
        poke_we   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one command; lat counts edges from the edge that samples start
    // to the first sample where Done is high.
    task automatic run_cmd(input logic [1:0] c_op, input logic [15:0] c_a,
                           input logic [15:0] c_b, input logic [15:0] c_d,
                           input logic [7:0] c_len, input int inject_at,
                           output int lat, output int busy_cyc, output logic done_at1);
        @(negedge clk);
        op = c_op; src_a = c_a; src_b = c_b; dst = c_d; len = c_len;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        done_at1 = Done;
        while (!Done && lat < 2000) begin
            if (busy) busy_cyc++;
            if (lat == inject_at) begin
                start = 1'b1;
                len   = 8'd7;
                op    = ~c_op;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_reached", {31'd0, Done}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin : main
        int   lat, bc, w0, r0, seen, n;
        logic d1;

        vt[0] = '{2'b00, 16'hFFFF, 16'h0002, 16'h0001};
        vt[1] = '{2'b01, 16'h0005, 16'h0007, 16'hFFFE};
        vt[2] = '{2'b10, 16'hF0F0, 16'h3C3C, 16'h3030};
        vt[3] = '{2'b11, 16'hF0F0, 16'h0F01, 16'hFFF1};
        vt[4] = '{2'b00, 16'h1234, 16'h4321, 16'h5555};
        vt[5] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF};

        reset = 1'b1; start = 1'b0; op = '0;
        src_a = '0; src_b = '0; dst = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",  {31'd0, busy},   32'd0);
        check("rst_done",  {31'd0, Done},   32'd0);
        check("rst_rd",    {31'd0, mem_rd}, 32'd0);
        check("rst_wr",    {31'd0, mem_wr}, 32'd0);
        check("rst_count", cycle_count,     32'd0);
        check("rst_addr",  {16'd0, mem_addr}, 32'd0);

        // Single-element vectors covering every op and the wrap cases
        for (int k = 0; k < 6; k++) begin
            poke(16'd100, vt[k].a);
            poke(16'd200, vt[k].b);
            run_cmd(vt[k].op, 16'd100, 16'd200, 16'(300 + k), 8'd1, 0, lat, bc, d1);
            check($sformatf("vec%0d_result", k), {16'd0, mem[300 + k]}, {16'd0, vt[k].exp});
            check($sformatf("vec%0d_count", k), cycle_count, 32'd3);
        end

        // len=4 add: latency, count and write strobes
        for (int k = 0; k < 4; k++) begin
            poke(16'(10 + k), 16'(k + 1));
            poke(16'(20 + k), 16'(10 * (k + 1)));
        end
        w0 = wr_cnt;
        run_cmd(2'b00, 16'd10, 16'd20, 16'd30, 8'd4, 0, lat, bc, d1);
        for (int k = 0; k < 4; k++)
            check($sformatf("add4_mem%0d", k), {16'd0, mem[30 + k]}, 32'(11 * (k + 1)));
        check("add4_latency", lat - 1, 32'd12);
        check("add4_busy",    bc, 32'd12);
        check("add4_count",   cycle_count, 32'd12);
        check("add4_writes",  wr_cnt - w0, 32'd4);

        // Address wrap with a borrowing subtract
        poke(16'hFFFF, 16'h0000);
        poke(16'h0000, 16'h0001);
        rd_log.delete();
        run_cmd(2'b01, 16'hFFFF, 16'h0000, 16'hFFFE, 8'd1, 0, lat, bc, d1);
        check("wrap_result", {16'd0, mem[16'hFFFE]}, 32'h0000FFFF);
        check("wrap_nreads", rd_log.size(), 32'd2);
        if (rd_log.size() == 2) begin
            check("wrap_rd_a_addr", {16'd0, rd_log[0]}, 32'h0000FFFF);
            check("wrap_rd_b_addr", {16'd0, rd_log[1]}, 32'h00000000);
        end

        // len=0 from IDLE: straight to DONE, no memory traffic
        pulse_reset();
        r0 = rd_cnt; w0 = wr_cnt;
        run_cmd(2'b00, 16'd10, 16'd20, 16'd700, 8'd0, 0, lat, bc, d1);
        check("len0_latency", lat, 32'd1);
        check("len0_count",   cycle_count, 32'd0);
        check("len0_reads",   rd_cnt - r0, 32'd0);
        check("len0_writes",  wr_cnt - w0, 32'd0);

        // start while busy is dropped; then a start in DONE re-arms
        w0 = wr_cnt;
        run_cmd(2'b00, 16'd10, 16'd20, 16'd40, 8'd3, 3, lat, bc, d1);
        check("mid_latency", lat - 1, 32'd9);
        check("mid_count",   cycle_count, 32'd9);
        check("mid_writes",  wr_cnt - w0, 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("mid_mem%0d", k), {16'd0, mem[40 + k]}, 32'(11 * (k + 1)));
        run_cmd(2'b11, 16'd10, 16'd20, 16'd50, 8'd1, 0, lat, bc, d1);
        check("rearm_done_cleared", {31'd0, d1}, 32'd0);
        check("rearm_result", {16'd0, mem[50]}, 32'h0000000B);
        check("rearm_count",  cycle_count, 32'd3);

        // In-place AND, reset during the 5th write cycle
        for (int k = 0; k < 8; k++) begin
            poke(16'(400 + k), 16'hFF00 | 16'(k));
            poke(16'(500 + k), 16'h0F0F);
        end
        w0 = wr_cnt;
        @(negedge clk);
        op = 2'b10; src_a = 16'd400; src_b = 16'd500; dst = 16'd400; len = 8'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        n = 0;
        while (n < 200) begin
            if (mem_wr) begin
                seen++;
                if (seen == 5) break;
            end
            @(negedge clk);
            n++;
        end
        check("abort_wr_reached", seen, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",  {31'd0, busy},   32'd0);
        check("abort_done",  {31'd0, Done},   32'd0);
        check("abort_rd",    {31'd0, mem_rd}, 32'd0);
        check("abort_wr",    {31'd0, mem_wr}, 32'd0);
        check("abort_addr",  {16'd0, mem_addr},  32'd0);
        check("abort_wdata", {16'd0, mem_wdata}, 32'd0);
        check("abort_count", cycle_count, 32'd0);
        reset = 1'b0;
        check("abort_writes", wr_cnt - w0, 32'd4);
        for (int k = 0; k < 8; k++)
            check($sformatf("abort_mem%0d", k), {16'd0, mem[400 + k]},
                  (k < 4) ? 32'(16'h0F00 | 16'(k)) : 32'(16'hFF00 | 16'(k)));

        // Normal command after the abort
        run_cmd(2'b11, 16'd400, 16'd500, 16'd600, 8'd2, 0, lat, bc, d1);
        check("post_mem0",    {16'd0, mem[600]}, 32'h00000F0F);
        check("post_mem1",    {16'd0, mem[601]}, 32'h00000F0F);
        check("post_count",   cycle_count, 32'd6);
        check("post_latency", lat - 1, 32'd6);

        check("rd_wr_exclusive", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Control FSM for the memory-to-memory vector datapath.
- On a start command it walks a vector of `len` elements. For each element it reads A[i] and B[i] from the single-port data memory, applies the selected element-wise operation, and writes C[i] back to memory.
- It reports busy/Done status and an execution cycle count, which the top-level integration and benches use for completion detection and performance measurement.

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 16, element/data width.
- LEN_W, 8, width of vector length field (max 2^LEN_W-1 elements).
- CNT_W, 32, width of cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE or DONE.
- op  input  2  operation: 00 add, 01 sub (A-B), 10 and, 11 or.
- src_a  input  ADDR_W  base address of vector A.
- src_b  input  ADDR_W  base address of vector B.
- dst  input  ADDR_W  base address of result vector C.
- len  input  LEN_W  element count.
- mem_addr  output  ADDR_W  memory address.
- mem_rd  output  1  read enable; data returns on mem_rdata the following cycle.
- mem_wr  output  1  write enable; write occurs at the rising edge.
- mem_wdata  output  DATA_W  write data.
- mem_rdata  input  DATA_W  read data (1-cycle synchronous latency).
- busy  output  1  high while a command is executing.
- Done  output  1  level; high from completion until the next accepted start or reset.
- cycle_count  output  CNT_W  cycles spent busy on the last/current command.

Behaviour:
- Reset values:
  - State is IDLE.
  - mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0.
  - busy=0, Done=0, cycle_count=0.
  - Internal index i=0 and A register = 0.
- Command capture: on an accepted start, latch op, src_a, src_b, dst and len; clear i and cycle_count; clear Done.
- Inputs other than mem_rdata are ignored while busy. A start asserted while busy is dropped (not queued).
- States:
  - IDLE: wait for start. With start and len!=0, go to RD_A. With start and len==0, go to DONE.
  - RD_A: mem_addr=src_a+i, mem_rd=1. Go to RD_B.
  - RD_B: mem_addr=src_b+i, mem_rd=1, A register <= mem_rdata. Go to WR.
  - WR: mem_addr=dst+i, mem_wr=1, mem_wdata=f(op, A register, mem_rdata), mem_rd=0.
    - If i==len-1, go to DONE.
    - Otherwise i<=i+1 and go to RD_A.
  - DONE: Done=1, busy=0. A start follows the same rules as in IDLE.
- busy is 1 in RD_A, RD_B and WR; 0 in IDLE and DONE.
- Memory control outputs are combinational from state/index. mem_rd and mem_wr are never both 1.
- Timing:
  - Exactly 3 cycles per element.
  - Done rises 3*len cycles after the cycle in which start is accepted.
  - For len==0, Done rises 1 cycle after the accepted start.
- cycle_count increments once per cycle while busy=1. It is held in DONE/IDLE, so it equals 3*len after completion.
- Arithmetic:
  - All element results are modulo 2^DATA_W. No flags; overflow and borrow are discarded.
  - Address sums are modulo 2^ADDR_W; a wrap past the top of memory continues at 0.
- Aliasing: element i is fully read before it is written, so dst==src_a or dst==src_b (in-place) is legal and correct. Partial overlaps with dst>src give forward-propagated results; this is defined, not an error.
- Reset mid-operation:
  - Aborts immediately: outputs return to reset values on the next edge.
  - No further memory writes occur.
  - Elements already written remain in memory.

Test Plan:
- Reset for 2 cycles, then idle -> busy=0, Done=0, mem_rd=mem_wr=0, cycle_count=0.
- A[10..13]={1,2,3,4}, B[20..23]={10,20,30,40}, op=00, dst=30, len=4 -> mem[30..33]={11,22,33,44}. Done rises exactly 12 cycles after start accepted; cycle_count=12; exactly 4 write strobes.
- op=01, A=0x0000, B=0x0001, len=1, src_a=0xFFFF, src_b=0x0000, dst=0xFFFE -> mem[0xFFFE]=0xFFFF (wrapping sub; src_a address 0xFFFF used, no out-of-range access).
- len=0, start -> no mem_rd/mem_wr ever asserted; Done=1 one cycle later; cycle_count=0.
- start pulsed again mid-command with different len -> ignored; original command completes with its own count; Done=1, then a new start in DONE clears Done and runs.
- op=10, dst=src_a, len=8, reset asserted on the 5th WR cycle -> exactly 4 elements updated, remainder unchanged. Outputs at reset values the cycle after reset, and a subsequent command runs normally.
